// File: rtl/fetch_unit_if.sv
// Fetch stage bus: hazard/redirect controls in, instruction memory
// address/data, and the IF/ID pipeline register out to decode.
interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic               jump;
    logic [PC_W-1:0]    jump_target;
    logic               halt_req;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr_in;
    logic [INSTR_W-1:0] if_id_instr;
    logic [PC_W-1:0]    if_id_pc;
    logic               if_id_valid;
    logic               halted;
    logic [15:0]        fetch_count;

    // Drives controls and memory data into the fetch stage
    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               halt_req, instr_in,
        input  pc_out, if_id_instr, if_id_pc, if_id_valid, halted,
               fetch_count
    );

    // The fetch stage itself
    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               halt_req, instr_in,
        output pc_out, if_id_instr, if_id_pc, if_id_valid, halted,
               fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and
// fills the IF/ID register. Handles stall, redirect with wrong-path
// flush, and a sticky halt that only reset can clear.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic [15:0]        count_q, count_d;

    // Next-state logic; redirect outranks halt, which outranks stall
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        if_pc_d  = if_pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b0;
            end
            RUN: begin
                if (bus.jump || bus.branch_taken) begin
                    pc_d    = bus.jump ? bus.jump_target : bus.branch_target;
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (bus.halt_req) begin
                    valid_d  = 1'b0;
                    instr_d  = '0;
                    halted_d = 1'b1;
                    state_d  = HALTED;
                end else if (!bus.stall) begin
                    instr_d = bus.instr_in;
                    if_pc_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                    count_d = count_q + 16'd1;
                end
            end
            HALTED: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and registered outputs; reset is asynchronous
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            if_pc_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            if_pc_q  <= if_pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = if_pc_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, all checked against a behavioural fetch model.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fetch_unit_if #(.PC_W(8), .INSTR_W(16)) bus ();

    fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [256];
    assign bus.instr_in = mem[bus.pc_out];

    int testCount = 0;
    int failCount = 0;

    // Behavioural model: 0 = boot, 1 = running, 2 = halted
    int          mPhase;
    logic [7:0]  mPc;
    logic [7:0]  mIfPc;
    logic [15:0] mInstr;
    logic        mValid;
    logic        mHalted;
    logic [15:0] mCount;

    task automatic modelReset();
        mPhase  = 0;
        mPc     = 8'h00;
        mIfPc   = 8'h00;
        mInstr  = 16'h0000;
        mValid  = 1'b0;
        mHalted = 1'b0;
        mCount  = 16'h0000;
    endtask

    task automatic modelStep(input logic st, input logic br, input logic [7:0] bt,
                             input logic j, input logic [7:0] jt, input logic h);
        int nextPc;
        if (mPhase == 0) begin
            mPhase = 1;
        end else if (mPhase == 1) begin
            if (j || br) begin
                mPc    = j ? jt : bt;
                mValid = 1'b0;
                mInstr = 16'h0000;
            end else if (h) begin
                mValid  = 1'b0;
                mInstr  = 16'h0000;
                mHalted = 1'b1;
                mPhase  = 2;
            end else if (!st) begin
                mInstr = mem[mPc];
                mIfPc  = mPc;
                mValid = 1'b1;
                nextPc = (int'(mPc) + 1) % 256;
                mPc    = 8'(nextPc);
                mCount = 16'((int'(mCount) + 1) % 65536);
            end
        end
    endtask

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check1({tag, ".pc_out"},      32'(bus.pc_out),      32'(mPc));
        check1({tag, ".if_id_instr"}, 32'(bus.if_id_instr), 32'(mInstr));
        check1({tag, ".if_id_pc"},    32'(bus.if_id_pc),    32'(mIfPc));
        check1({tag, ".if_id_valid"}, 32'(bus.if_id_valid), 32'(mValid));
        check1({tag, ".halted"},      32'(bus.halted),      32'(mHalted));
        check1({tag, ".fetch_count"}, 32'(bus.fetch_count), 32'(mCount));
    endtask

    // Drives one cycle of inputs (called away from the edge), checks #1 after
    // the rising edge, and returns on the following falling edge.
    task automatic applyStimulus(input string tag, input logic st, input logic br,
                                 input logic [7:0] bt, input logic j,
                                 input logic [7:0] jt, input logic h);
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = bt;
        bus.jump          = j;
        bus.jump_target   = jt;
        bus.halt_req      = h;
        @(posedge clk);
        modelStep(st, br, bt, j, jt, h);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    // Asserts reset mid low-phase, checks it takes effect without an edge,
    // holds it across one edge, then releases on the falling edge.
    task automatic doReset(input string tag);
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 8'h00;
        bus.jump = 1'b0; bus.jump_target = 8'h00; bus.halt_req = 1'b0;
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput({tag, ".async"});
        @(posedge clk);
        #1;
        checkOutput({tag, ".held"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset release to edge 5 with memory[i] = 16'h1000 + i
    task automatic freeRunCheck(input string tag);
        idle({tag, ".e1"});
        check1({tag, ".e1_valid"}, 32'(bus.if_id_valid), 32'd0);
        idle({tag, ".e2"});
        check1({tag, ".e2_instr"}, 32'(bus.if_id_instr), 32'h1000);
        check1({tag, ".e2_pc"},    32'(bus.if_id_pc),    32'h0);
        check1({tag, ".e2_valid"}, 32'(bus.if_id_valid), 32'd1);
        idle({tag, ".e3"});
        idle({tag, ".e4"});
        idle({tag, ".e5"});
        check1({tag, ".e5_instr"}, 32'(bus.if_id_instr), 32'h1003);
        check1({tag, ".e5_pcout"}, 32'(bus.pc_out),      32'h4);
        check1({tag, ".e5_count"}, 32'(bus.fetch_count), 32'd4);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < 16) ? 16'(16'h1000 + i) : 16'($urandom);
        end
        modelReset();

        // Reset and free-run
        doReset("reset0");
        freeRunCheck("run0");

        // Stall three cycles at pc_out = 5
        idle("to_pc5");
        check1("pc5", 32'(bus.pc_out), 32'h5);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            check1("stall_pc", 32'(bus.pc_out), 32'h5);
        end
        idle("after_stall");
        check1("after_stall_instr", 32'(bus.if_id_instr), 32'h1005);
        check1("after_stall_pc",    32'(bus.pc_out),      32'h6);

        // Branch together with stall at pc_out = 7
        idle("to_pc7");
        applyStimulus("branch_stall", 1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 1'b0);
        check1("branch_pc",    32'(bus.pc_out),      32'h20);
        check1("branch_valid", 32'(bus.if_id_valid), 32'd0);
        idle("branch_land");
        check1("branch_land_pc",    32'(bus.if_id_pc),    32'h20);
        check1("branch_land_valid", 32'(bus.if_id_valid), 32'd1);

        // Jump and branch together: jump wins
        applyStimulus("jump_branch", 1'b0, 1'b1, 8'h30, 1'b1, 8'h40, 1'b0);
        check1("jump_wins", 32'(bus.pc_out), 32'h40);
        idle("jump_land");

        // PC wrap
        applyStimulus("jump_ff", 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
        idle("wrap_ff");
        check1("wrap_ff_pc", 32'(bus.if_id_pc), 32'hFF);
        idle("wrap_00");
        check1("wrap_00_pc",    32'(bus.if_id_pc),    32'h00);
        check1("wrap_00_valid", 32'(bus.if_id_valid), 32'd1);

        // Halt at pc_out = 3, then everything ignored
        doReset("reset_halt");
        for (int i = 0; i < 4; i++) idle("to_pc3");
        check1("pc3", 32'(bus.pc_out), 32'h3);
        applyStimulus("halt", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check1("halt_flag", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("halted_ign", 1'($urandom), 1'($urandom), 8'($urandom),
                          1'($urandom), 8'($urandom), 1'($urandom));
            check1("halted_pc", 32'(bus.pc_out), 32'h3);
        end

        // Async reset while running at pc_out = 9, then identical recovery
        doReset("reset_pre9");
        idle("boot9");
        applyStimulus("jump9", 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, 1'b0);
        check1("pc9", 32'(bus.pc_out), 32'h9);
        doReset("reset_mid");
        freeRunCheck("run1");

        // Randomized run with occasional halts recovered by reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", ($urandom % 4) == 0, ($urandom % 8) == 0, 8'($urandom),
                          ($urandom % 10) == 0, 8'($urandom), ($urandom % 60) == 0);
            if (mPhase == 2 && ($urandom % 4) == 0) doReset("rand_reset");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
